// File: rtl/dbg_instcache_pkg.sv
// Shared definitions for the instruction-cache debug observer: controller
// state encodings, cache line field positions and error flag indices.
package dbg_instcache_pkg;

  typedef enum logic [1:0] {
    S_CACHE   = 2'd0,
    S_ADDR    = 2'd1,
    S_DATA    = 2'd2,
    S_ILLEGAL = 2'd3
  } cache_state_e;

  localparam int LINE_W       = 89;
  localparam int LINE_VALID   = 88;
  localparam int LINE_TAG_HI  = 87;
  localparam int LINE_TAG_LO  = 64;
  localparam int LINE_DATA_HI = 63;
  localparam int LINE_DATA_LO = 0;

  localparam int ERR_W             = 6;
  localparam int ERR_ILLEGAL_STATE = 0;
  localparam int ERR_REQ_DROP      = 1;
  localparam int ERR_ADDR_UNSTABLE = 2;
  localparam int ERR_COMP_MISMATCH = 3;
  localparam int ERR_NO_REQ        = 4;
  localparam int ERR_HIT_INVALID   = 5;

  // RISC-V: an instruction is compressed unless its two low bits are 2'b11.
  function automatic logic is_compressed(input logic [1:0] low_bits);
    return ~&low_bits;
  endfunction

endpackage

// File: rtl/dbg_instcache_if.sv
// Read-only TileLink A/D channel subset seen by the instruction cache.
interface dbg_instcache_if;

  logic        a_valid;
  logic        a_ready;
  logic [63:0] a_address;
  logic        d_valid;
  logic        d_ready;
  logic [63:0] d_data;

  modport master (output a_valid, a_address, d_ready,
                  input  a_ready, d_valid, d_data);
  modport slave  (input  a_valid, a_address, d_ready,
                  output a_ready, d_valid, d_data);
  modport monitor (input a_valid, a_ready, a_address, d_valid, d_ready, d_data);

endinterface

// File: rtl/dbg_instcache_dff.sv
// History flop with async active-low reset, synchronous clear and enable.
module dff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage: clear takes priority over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (clear) begin
      q <= RESET_VAL;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dbg_instcache.sv
// Passive instruction-cache observer: event counters, last miss PC and sticky
// protocol error flags. Define DBG_INSTCACHE_TRACE_EN for a per-event trace.
module dbg_instcache
  import dbg_instcache_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [63:0]           pc,
  input  logic [1:0]            state,
  input  logic [LINE_W-1:0]     line,
  input  logic [LINE_W-1:0]     bh_line,
  input  logic [1:0]            req_bmp,
  input  logic                  inst_valid,
  input  logic                  inst_comp,
  input  logic [31:0]           inst,
  input  logic                  page_fault,
  input  logic                  invalid,
  input  logic                  request,
  dbg_instcache_if.monitor      bus,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt,
  output logic [CNT_W-1:0]      req_cnt,
  output logic [CNT_W-1:0]      fill_cnt,
  output logic [CNT_W-1:0]      fault_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [63:0]           miss_pc,
  output logic [ERR_W-1:0]      err,
  output logic                  err_any
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       prev_state_r;
  logic             prev_a_valid_r;
  logic             prev_a_ready_r;
  logic [63:0]      prev_a_address_r;
  logic             prev_page_fault_r;

  logic             hit_ev_s;
  logic             miss_ev_s;
  logic             req_ev_s;
  logic             fill_ev_s;
  logic             fault_ev_s;
  logic             flush_ev_s;
  logic             a_stalled_s;
  logic [ERR_W-1:0] err_cond_s;
  logic             unused_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    return (ev && (v != CNT_MAX)) ? (v + CNT_ONE) : v;
  endfunction

  dff #(.WIDTH(2))  u_prev_state (.clk(clk), .rst_n(rst_n), .clear(1'b0), .enable(1'b1),
                                  .d(state), .q(prev_state_r));
  dff #(.WIDTH(1))  u_prev_valid (.clk(clk), .rst_n(rst_n), .clear(1'b0), .enable(1'b1),
                                  .d(bus.a_valid), .q(prev_a_valid_r));
  dff #(.WIDTH(1))  u_prev_ready (.clk(clk), .rst_n(rst_n), .clear(1'b0), .enable(1'b1),
                                  .d(bus.a_ready), .q(prev_a_ready_r));
  dff #(.WIDTH(64)) u_prev_addr  (.clk(clk), .rst_n(rst_n), .clear(1'b0), .enable(1'b1),
                                  .d(bus.a_address), .q(prev_a_address_r));
  dff #(.WIDTH(1))  u_prev_pf    (.clk(clk), .rst_n(rst_n), .clear(1'b0), .enable(1'b1),
                                  .d(page_fault), .q(prev_page_fault_r));

  // Event decode for the counters.
  always_comb begin
    hit_ev_s   = (state == S_CACHE) && !invalid && inst_valid;
    miss_ev_s  = (prev_state_r == S_CACHE) && (state == S_ADDR);
    req_ev_s   = bus.a_valid && bus.a_ready;
    fill_ev_s  = bus.d_valid && bus.d_ready;
    fault_ev_s = (state == S_ADDR) && page_fault;
    flush_ev_s = invalid;
  end

  // Error conditions; the A-channel checks rely on a stall seen last cycle.
  always_comb begin
    a_stalled_s = prev_a_valid_r && !prev_a_ready_r;
    err_cond_s  = {ERR_W{1'b0}};
    err_cond_s[ERR_ILLEGAL_STATE] = (state == S_ILLEGAL);
    err_cond_s[ERR_REQ_DROP]      = a_stalled_s && !bus.a_valid && !prev_page_fault_r;
    err_cond_s[ERR_ADDR_UNSTABLE] = a_stalled_s && bus.a_valid &&
                                    (bus.a_address != prev_a_address_r);
    err_cond_s[ERR_COMP_MISMATCH] = (inst_comp != is_compressed(inst[1:0]));
    err_cond_s[ERR_NO_REQ]        = ((state == S_ADDR) || (state == S_DATA)) && (req_bmp == 2'b00);
    err_cond_s[ERR_HIT_INVALID]   = inst_valid && !invalid && !line[LINE_VALID];
  end

  // Saturating counters, last miss PC and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt   <= CNT_ZERO;
      miss_cnt  <= CNT_ZERO;
      req_cnt   <= CNT_ZERO;
      fill_cnt  <= CNT_ZERO;
      fault_cnt <= CNT_ZERO;
      flush_cnt <= CNT_ZERO;
      miss_pc   <= 64'h0;
      err       <= {ERR_W{1'b0}};
    end else begin
      hit_cnt   <= sat_inc(hit_cnt, hit_ev_s);
      miss_cnt  <= sat_inc(miss_cnt, miss_ev_s);
      req_cnt   <= sat_inc(req_cnt, req_ev_s);
      fill_cnt  <= sat_inc(fill_cnt, fill_ev_s);
      fault_cnt <= sat_inc(fault_cnt, fault_ev_s);
      flush_cnt <= sat_inc(flush_cnt, flush_ev_s);
      miss_pc   <= miss_ev_s ? pc : miss_pc;
      err       <= err | err_cond_s;
    end
  end

  assign err_any  = |err;
  assign unused_s = ^{line[LINE_TAG_HI:LINE_DATA_LO], bh_line, inst[31:2], request, bus.d_data};

`ifdef DBG_INSTCACHE_TRACE_EN
  localparam bit TRACE_ON = 1'b1;

  // Event trace, one line per miss, fill, page fault and newly set error.
  always @(posedge clk) begin
    if (rst_n) begin
      if (miss_ev_s)  $display("%0t dbg_instcache miss pc=%h", $time, pc);
      if (fill_ev_s)  $display("%0t dbg_instcache fill addr=%h data=%h", $time,
                               prev_a_address_r, bus.d_data);
      if (fault_ev_s) $display("%0t dbg_instcache page_fault pc=%h", $time, pc);
      if (|(err_cond_s & ~err)) $display("%0t dbg_instcache err_set bits=%b", $time,
                                         err_cond_s & ~err);
    end
  end
`else
  localparam bit TRACE_ON = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_instcache.sv
// Directed self-checking bench for dbg_instcache (CNT_W=32 and CNT_W=4 instances).
module tb_dbg_instcache;
  import dbg_instcache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] pc;
  logic [1:0]  state;
  logic [88:0] line, bh_line;
  logic [1:0]  req_bmp;
  logic        inst_valid, inst_comp, page_fault, invalid, request;
  logic [31:0] inst;

  logic [31:0] hit_cnt, miss_cnt, req_cnt, fill_cnt, fault_cnt, flush_cnt;
  logic [63:0] miss_pc;
  logic [5:0]  err;
  logic        err_any;
  logic [3:0]  s_hit, s_miss, s_req, s_fill, s_fault, s_flush;
  logic [63:0] s_miss_pc;
  logic [5:0]  s_err;
  logic        s_err_any;

  int checks = 0;
  int failures = 0;

  dbg_instcache_if bus_if ();

  dbg_instcache dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .state(state), .line(line), .bh_line(bh_line),
    .req_bmp(req_bmp), .inst_valid(inst_valid), .inst_comp(inst_comp), .inst(inst),
    .page_fault(page_fault), .invalid(invalid), .request(request), .bus(bus_if),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .req_cnt(req_cnt), .fill_cnt(fill_cnt),
    .fault_cnt(fault_cnt), .flush_cnt(flush_cnt), .miss_pc(miss_pc), .err(err),
    .err_any(err_any)
  );

  dbg_instcache #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pc(pc), .state(state), .line(line), .bh_line(bh_line),
    .req_bmp(req_bmp), .inst_valid(inst_valid), .inst_comp(inst_comp), .inst(inst),
    .page_fault(page_fault), .invalid(invalid), .request(request), .bus(bus_if),
    .hit_cnt(s_hit), .miss_cnt(s_miss), .req_cnt(s_req), .fill_cnt(s_fill),
    .fault_cnt(s_fault), .flush_cnt(s_flush), .miss_pc(s_miss_pc), .err(s_err),
    .err_any(s_err_any)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    pc = 64'h0; state = 2'd0; line = {1'b1, 88'h0}; bh_line = 89'h0; req_bmp = 2'b00;
    inst_valid = 1'b0; inst_comp = 1'b1; inst = 32'h0; page_fault = 1'b0;
    invalid = 1'b0; request = 1'b0;
    bus_if.a_valid = 1'b0; bus_if.a_ready = 1'b0; bus_if.a_address = 64'h0;
    bus_if.d_valid = 1'b0; bus_if.d_ready = 1'b0; bus_if.d_data = 64'h0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_idle();
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({hit_cnt, miss_cnt, req_cnt, fill_cnt, fault_cnt, flush_cnt} !== 192'h0) begin
      $display("FAIL %s counters: got %h %h %h %h %h %h, want all 0", tag,
               hit_cnt, miss_cnt, req_cnt, fill_cnt, fault_cnt, flush_cnt);
      failures++;
    end
    checks++;
    if (miss_pc !== 64'h0 || err !== 6'h0 || err_any !== 1'b0) begin
      $display("FAIL %s miss_pc/err: got %h %b %b, want 0 0 0", tag, miss_pc, err, err_any);
      failures++;
    end
    checks++;
    if ({s_fill, s_hit, s_err} !== 14'h0) begin
      $display("FAIL %s sat_dut: got fill=%h hit=%h err=%b, want 0", tag, s_fill, s_hit, s_err);
      failures++;
    end
  endtask

  task automatic test_reset();
    set_idle();
    #12;
    check_all_zero("reset_hold");
    do_reset();
    tick(1);
    check_all_zero("reset_first_cycle");
  endtask

  task automatic test_hits();
    do_reset();
    inst_valid = 1'b1;
    tick(5);
    inst_valid = 1'b0;
    tick(1);
    checks++;
    if (hit_cnt !== 32'd5) begin
      $display("FAIL hit_cnt: got %0d, want 5", hit_cnt); failures++;
    end
    checks++;
    if (err !== 6'h0) begin
      $display("FAIL hit_err: got %b, want 000000", err); failures++;
    end
  endtask

  task automatic test_miss();
    do_reset();
    state = 2'd1; pc = 64'h8000_0010; req_bmp = 2'b01; page_fault = 1'b1;
    tick(1);
    state = 2'd2; pc = 64'h8000_0020; page_fault = 1'b0;
    tick(1);
    state = 2'd0; req_bmp = 2'b00;
    tick(1);
    checks++;
    if (miss_cnt !== 32'd1 || miss_pc !== 64'h8000_0010) begin
      $display("FAIL miss: got cnt=%0d pc=%h, want 1 0000000080000010", miss_cnt, miss_pc);
      failures++;
    end
    checks++;
    if (fault_cnt !== 32'd1 || err !== 6'h0) begin
      $display("FAIL miss_fault: got fault=%0d err=%b, want 1 000000", fault_cnt, err);
      failures++;
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    bus_if.a_valid = 1'b1; bus_if.a_address = 64'h1000;
    tick(1);
    bus_if.a_valid = 1'b0;
    tick(1);
    checks++;
    if (err !== 6'b000010 || err_any !== 1'b1) begin
      $display("FAIL req_drop: got err=%b any=%b, want 000010 1", err, err_any); failures++;
    end
    tick(3);
    checks++;
    if (err !== 6'b000010 || err_any !== 1'b1) begin
      $display("FAIL req_drop_sticky: got err=%b any=%b, want 000010 1", err, err_any);
      failures++;
    end
  endtask

  task automatic test_addr_unstable();
    do_reset();
    bus_if.a_valid = 1'b1; bus_if.a_address = 64'h2000;
    tick(1);
    bus_if.a_address = 64'h2040; bus_if.a_ready = 1'b1;
    tick(1);
    bus_if.a_valid = 1'b0; bus_if.a_ready = 1'b0;
    tick(1);
    checks++;
    if (err !== 6'b000100 || req_cnt !== 32'd1) begin
      $display("FAIL addr_unstable: got err=%b req=%0d, want 000100 1", err, req_cnt);
      failures++;
    end
  endtask

  task automatic test_comp();
    do_reset();
    inst = 32'h0000_4501; inst_comp = 1'b1;
    tick(1);
    checks++;
    if (err !== 6'h0) begin
      $display("FAIL comp_ok: got %b, want 000000", err); failures++;
    end
    inst = 32'h0000_0013;
    tick(1);
    inst = 32'h0;
    tick(1);
    checks++;
    if (err !== 6'b001000 || err_any !== 1'b1) begin
      $display("FAIL comp_bad: got err=%b any=%b, want 001000 1", err, err_any); failures++;
    end
  endtask

  task automatic test_no_req_hit_invalid();
    do_reset();
    state = 2'd0; inst_valid = 1'b1; line = 89'h0;
    tick(1);
    inst_valid = 1'b0; line = {1'b1, 88'h0}; state = 2'd1; req_bmp = 2'b00;
    tick(1);
    state = 2'd0;
    tick(1);
    checks++;
    if (err !== 6'b110000) begin
      $display("FAIL no_req_hit_invalid: got %b, want 110000", err); failures++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_if.a_valid = 1'b1; bus_if.a_ready = 1'b1;
    bus_if.d_valid = 1'b1; bus_if.d_ready = 1'b1; invalid = 1'b1; inst_valid = 1'b1;
    tick(3);
    set_idle();
    tick(1);
    checks++;
    if (req_cnt !== 32'd3 || fill_cnt !== 32'd3 || flush_cnt !== 32'd3 || hit_cnt !== 32'd0) begin
      $display("FAIL multi: got req=%0d fill=%0d flush=%0d hit=%0d, want 3 3 3 0",
               req_cnt, fill_cnt, flush_cnt, hit_cnt);
      failures++;
    end
    checks++;
    if (err !== 6'h0) begin
      $display("FAIL multi_err: got %b, want 000000", err); failures++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    bus_if.d_valid = 1'b1; bus_if.d_ready = 1'b1;
    tick(14);
    checks++;
    if (s_fill !== 4'd14) begin
      $display("FAIL sat_pre: got %0d, want 14", s_fill); failures++;
    end
    tick(6);
    bus_if.d_valid = 1'b0; bus_if.d_ready = 1'b0;
    tick(1);
    checks++;
    if (s_fill !== 4'd15 || fill_cnt !== 32'd20) begin
      $display("FAIL sat_fill: got small=%0d wide=%0d, want 15 20", s_fill, fill_cnt);
      failures++;
    end
  endtask

  task automatic test_illegal_then_reset();
    do_reset();
    state = 2'd1; req_bmp = 2'b01; pc = 64'hDEAD_0000;
    tick(1);
    state = 2'd3;
    tick(1);
    state = 2'd0; req_bmp = 2'b00;
    tick(1);
    checks++;
    if (err !== 6'b000001 || err_any !== 1'b1 || miss_cnt !== 32'd1) begin
      $display("FAIL illegal_state: got err=%b any=%b miss=%0d, want 000001 1 1",
               err, err_any, miss_cnt);
      failures++;
    end
    rst_n = 1'b0;
    #3;
    check_all_zero("async_reset");
    rst_n = 1'b1;
    tick(1);
    check_all_zero("after_reset");
  endtask

  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_req_drop();
    test_addr_unstable();
    test_comp();
    test_no_req_hit_invalid();
    test_back_to_back();
    test_saturate();
    test_illegal_then_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbg_instcache.md
DBG_INSTCACHE -- requirements
Module: dbg_instcache

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of every event counter.
REQ-002 SHALL have input clk, 1 bit, clock; all state updates on the rising edge.
REQ-003 SHALL have input rst_n, 1 bit, reset, asynchronous, active-low.
REQ-004 SHALL have input pc, 64 bits, current fetch PC.
REQ-005 SHALL have input state, 2 bits, cache controller state: 0 CACHE, 1 ADDR, 2 DATA.
REQ-006 SHALL have inputs line and bh_line, 89 bits each, cache line at the PC index and at the back-half index; bit 88 is valid, bits 87:64 are tag, bits 63:0 are data.
REQ-007 SHALL have input req_bmp, 2 bits, outstanding-refill bitmap.
REQ-008 SHALL have inputs inst_valid (1 bit), inst_comp (1 bit), inst (32 bits), page_fault (1 bit), invalid (1 bit) and request (1 bit).
REQ-009 SHALL have bus, a TileLink interface port that is read-only; it uses a_valid, a_ready, a_address[63:0], d_valid, d_ready and d_data[63:0].
REQ-010 SHALL have outputs hit_cnt, miss_cnt, req_cnt, fill_cnt, fault_cnt and flush_cnt, each CNT_W bits, event counters.
REQ-011 SHALL have output miss_pc, 64 bits, the PC of the most recent miss.
REQ-012 SHALL have output err, 6 bits, sticky error flags; SHALL have output err_any, 1 bit, equal to the OR of err.

Function
REQ-013 SHALL drive no signal into bus or the cache; the block is a pure observer.
REQ-014 SHALL increment hit_cnt on each cycle with state==0, ~invalid and inst_valid.
REQ-015 SHALL increment miss_cnt and load miss_pc<=pc on each registered transition of state from 0 to 1; detection uses the previous state held in a dff.
REQ-016 SHALL increment req_cnt on each cycle with a_valid & a_ready.
REQ-017 SHALL increment fill_cnt on each cycle with d_valid & d_ready.
REQ-018 SHALL increment fault_cnt on each cycle with state==1 & page_fault.
REQ-019 SHALL increment flush_cnt on each cycle with invalid high.
REQ-020 SHALL saturate every counter at all-ones, with no wrap-around.
REQ-021 SHALL allow several counters to update in the same cycle, independently.
REQ-022 SHALL set err[0] when state==3 (illegal state).
REQ-023 SHALL set err[1] when a_valid was high and a_ready low in the previous cycle and a_valid is now low while page_fault was low in the previous cycle (request dropped).
REQ-024 SHALL set err[2] when a_valid was high and a_ready low in the previous cycle and a_address now differs while a_valid is still high (address unstable).
REQ-025 SHALL set err[3] when inst_comp != ~&inst[1:0].
REQ-026 SHALL set err[4] when state is 1 or 2 and req_bmp==0.
REQ-027 SHALL set err[5] when inst_valid & ~invalid & ~line[88] (hit reported on an invalid line).
REQ-028 SHALL set error flags one cycle after the condition; flags stay set until reset.
REQ-029 SHALL drive err_any combinationally from err.

Reset
REQ-030 SHALL clear, on rst_n low at any time including mid-refill, all counters, miss_pc, err and the history registers (previous state, a_valid, a_ready, a_address, page_fault) to 0.
REQ-031 SHALL not flag errors in the first cycle after reset release, because history is 0.

Configuration
REQ-032 SHALL, when DBG_INSTCACHE_TRACE_EN is defined, $display one line per miss (time, pc), fill (address, d_data), page fault and error set.
REQ-033 SHALL, without DBG_INSTCACHE_TRACE_EN, emit no display, with counters and errors behaving identically.

Structure
REQ-034 SHALL use a shared package holding the state encodings (S_CACHE=0, S_ADDR=1, S_DATA=2), the line field positions (VALID 88, TAG 87:64, DATA 63:0) and the error bit indices.
REQ-035 SHALL use sub-module dff (parameters width and reset value; ports clk, rst_n, clear, enable, d, q) for all history registers.

Verification
REQ-036 SHALL cover: reset, then state=0, inst_valid=1 for 5 cycles -> hit_cnt=5, err=0.
REQ-037 SHALL cover: state 0->1 with pc=0x80000010 -> miss_cnt=1, miss_pc=0x80000010.
REQ-038 SHALL cover: a_valid=1, a_ready=0, then a_valid=0 with no page fault -> err[1]=1, err_any=1, held after the cause is removed.
REQ-039 SHALL cover: inst=0x00000013 with inst_comp=1 -> err[3]=1; inst=0x4501 with inst_comp=1 -> no error.
REQ-040 SHALL cover: CNT_W=4 with 20 fill beats -> fill_cnt=15 (saturated).
REQ-041 SHALL cover: state=3 for one cycle, then rst_n pulse -> err[0]=1, then all outputs 0.
